// File: rtl/mem_bank_reader.sv
// Egress read controller for one port's frame bank: queues frame descriptors,
// streams each frame's words out with backpressure and an inter-frame gap.
module mem_bank_reader #(
  parameter int pPORT_WIDTH = 4,
  parameter int pADDR_W     = 10,
  parameter int pDESC_DEPTH = 4,
  parameter int pIFG        = 3
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_desc_valid,
  output logic                           o_desc_ready,
  input  logic [pADDR_W-1:0]             i_desc_addr,
  input  logic [pADDR_W-1:0]             i_desc_len,
  input  logic [$clog2(pPORT_WIDTH)-1:0] i_desc_src,
  output logic                           o_rd_en,
  output logic [pADDR_W-1:0]             o_rd_addr,
  input  logic [31:0]                    i_mem_data,
  input  logic [1:0]                     i_mem_info,
  input  logic [1:0]                     i_mem_extra,
  output logic [31:0]                    o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [1:0]                     o_info_port,
  output logic [1:0]                     o_extra_byte,
  output logic [$clog2(pPORT_WIDTH)-1:0] o_port_num,
  output logic                           o_free_valid,
  output logic [pADDR_W-1:0]             o_free_len,
  output logic                           o_err
);

  localparam int SRC_W = $clog2(pPORT_WIDTH);
  localparam int PTR_W = (pDESC_DEPTH > 1) ? $clog2(pDESC_DEPTH) : 1;
  localparam int GAP_W = $clog2(pIFG + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN, S_GAP} state_t;

  state_t state, state_next;

  logic [pADDR_W-1:0] fifo_addr [pDESC_DEPTH];
  logic [pADDR_W-1:0] fifo_len  [pDESC_DEPTH];
  logic [SRC_W-1:0]   fifo_src  [pDESC_DEPTH];
  logic [PTR_W-1:0]   fifo_wr, fifo_rd;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_empty, desc_push, desc_zero, desc_pop;

  logic [pADDR_W-1:0] rd_addr, remaining, frame_len, ret_idx;
  logic [SRC_W-1:0]   src;
  logic               inflight, rd_en, free_valid, err_q;
  logic [GAP_W-1:0]   gap_cnt;

  logic [31:0]        buf_data  [2];
  logic [1:0]         buf_info  [2];
  logic [1:0]         buf_extra [2];
  logic               buf_head, buf_tail, buf_pop, space;
  logic [1:0]         buf_count;
  logic [2:0]         occ_after;
  logic [1:0]         exp_info;

  assign o_desc_ready = fifo_count != (PTR_W+1)'(pDESC_DEPTH);
  assign fifo_empty   = fifo_count == '0;
  assign desc_push    = i_desc_valid && o_desc_ready && (i_desc_len != '0);
  assign desc_zero    = i_desc_valid && o_desc_ready && (i_desc_len == '0);

  always_ff @(posedge i_clk) begin
    if (desc_push) begin
      fifo_addr[fifo_wr] <= i_desc_addr;
      fifo_len[fifo_wr]  <= i_desc_len;
      fifo_src[fifo_wr]  <= i_desc_src;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (desc_push) fifo_wr <= fifo_wr + 1'b1;
      if (desc_pop)  fifo_rd <= fifo_rd + 1'b1;
      case ({desc_push, desc_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Reads are issued only while buffer plus the in-flight word leaves room after this cycle's pop.
  assign buf_pop   = o_valid && i_ready;
  assign occ_after = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, buf_pop};
  assign space     = occ_after < 3'd2;

  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    desc_pop   = 1'b0;
    rd_en      = 1'b0;
    free_valid = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) state_next = S_LOAD;
      S_LOAD: begin
        desc_pop   = 1'b1;
        state_next = S_READ;
      end
      S_READ: begin
        if (space) begin
          rd_en = 1'b1;
          if (remaining == pADDR_W'(1)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight && buf_count == 2'd0) begin
          free_valid = 1'b1;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(pIFG - 1)) state_next = fifo_empty ? S_IDLE : S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Position-derived info; a stored value that disagrees is reported and replaced.
  assign exp_info = {ret_idx == frame_len - pADDR_W'(1), ret_idx == '0};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rd_addr   <= '0;
      remaining <= '0;
      frame_len <= '0;
      ret_idx   <= '0;
      src       <= '0;
      inflight  <= 1'b0;
      err_q     <= 1'b0;
      gap_cnt   <= '0;
      buf_head  <= 1'b0;
      buf_tail  <= 1'b0;
      buf_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i]  <= '0;
        buf_info[i]  <= '0;
        buf_extra[i] <= '0;
      end
    end else begin
      inflight <= rd_en;
      err_q    <= desc_zero || (inflight && (i_mem_info != exp_info));
      gap_cnt  <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      if (desc_pop) begin
        rd_addr   <= fifo_addr[fifo_rd];
        remaining <= fifo_len[fifo_rd];
        frame_len <= fifo_len[fifo_rd];
        src       <= fifo_src[fifo_rd];
        ret_idx   <= '0;
      end else begin
        if (rd_en) begin
          rd_addr   <= rd_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        if (inflight) ret_idx <= ret_idx + 1'b1;
      end
      if (inflight) begin
        buf_data[buf_tail]  <= i_mem_data;
        buf_info[buf_tail]  <= exp_info;
        buf_extra[buf_tail] <= exp_info[1] ? i_mem_extra : 2'b00;
        buf_tail            <= ~buf_tail;
      end
      if (buf_pop) buf_head <= ~buf_head;
      case ({inflight, buf_pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  assign o_rd_en      = rd_en;
  assign o_rd_addr    = rd_addr;
  assign o_valid      = buf_count != 2'd0;
  assign o_data       = buf_data[buf_head];
  assign o_info_port  = buf_info[buf_head];
  assign o_extra_byte = buf_extra[buf_head];
  assign o_port_num   = src;
  assign o_free_valid = free_valid;
  assign o_free_len   = free_valid ? frame_len : '0;
  assign o_err        = err_q;

endmodule
